partition_sweep_checker: RTL and testbench
==========================================

Name: partition_sweep_checker

Overview:
- Synthesizable, parametrised exhaustive-sweep engine for approximate-logic partitions.
- Drives a primary-input vector `pi` through all 2^NI values in ascending order, from 0 to 2^NI-1.
- Compares the exact partition output against the approximate partition output and accumulates error metrics: mismatch count, maximum absolute error and summed absolute error.
- Sits beside two partition instances (exact and approximate) that share `pi`. It replaces per-vector display dumps with on-chip metric collection, and it tolerates partitions that have pipeline latency.

Parameters:
- NI, 7, primary-input width; the sweep length is 2^NI vectors (NI range 1..20).
- NO, 4, primary-output width of each partition; outputs are treated as unsigned.
- LAT, 0, pipeline latency of the partitions in cycles (range 0..8). A `po` value corresponds to the `pi` value driven LAT cycles earlier.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep.
- hold  input  1  pause the issue of new vectors.
- exact_po  input  NO  exact partition output.
- approx_po  input  NO  approximate partition output.
- pi  output  NI  vector driven to both partitions.
- busy  output  1  high from SWEEP through the end of DRAIN.
- done  output  1  high in DONE; metrics are final.
- err_count  output  NI+1  number of vectors where exact_po != approx_po.
- max_err  output  NO  maximum |exact_po - approx_po| seen.
- sum_err  output  NO+NI  sum of |exact_po - approx_po| over all vectors.

Behaviour:
- Reset (rst=1 at a clock edge) clears the following, in any state, including mid-sweep:
  - state to IDLE;
  - `pi`, `busy`, `done` and all metrics to 0;
  - the valid pipeline is flushed.
- State machine (IDLE, SWEEP, DRAIN, DONE):
  - IDLE: on start=1, clear the metrics, set pi=0 and go to SWEEP.
  - SWEEP:
    - Each cycle with hold=0 issues the current `pi` value, tagging a valid bit into a LAT-deep shift register (a direct wire when LAT=0), then increments `pi`.
    - With hold=1, `pi` is frozen and a bubble (valid=0) is issued. In-flight vectors keep advancing and are still scored.
    - After issuing `pi` = 2^NI-1, `pi` wraps to 0 and the state goes to DRAIN (or directly to DONE when LAT=0).
  - DRAIN: lasts LAT cycles; `hold` is ignored. Then go to DONE.
  - DONE: done=1 and `pi` holds 0. On start=1, behave as in IDLE (restart).
- `start` is ignored while busy=1.
- If rst and start are both 1 at the same edge, reset wins.
- Scoring happens on every cycle where the delayed valid bit is 1:
  - d = |exact_po - approx_po|, computed as NO-bit unsigned magnitude.
  - err_count increments if d != 0.
  - sum_err += d, zero-extended.
  - max_err = max(max_err, d).
  - The metric registers update at the clock edge ending that cycle.
  - Widths are sized so that no overflow is possible.
- Timing with hold=0 throughout:
  - busy rises on the edge that samples start.
  - done rises exactly 2^NI + LAT edges after the start edge; busy falls on the same edge.
  - Metrics are final and stable while done=1.
- Each hold cycle spent in SWEEP delays done by exactly one cycle.
- Outputs are registered except where LAT=0 requires same-cycle scoring of the combinational `po`.

Optional Feature:
- Macro: TT_SIGNATURE_EN.
- When defined:
  - Adds output `signature` [31:0], a MISR over exact_po for each scored vector.
  - Update rule: sig <= ({sig[30:0],1'b0} ^ (sig[31] ? 32'h0040_0007 : 32'h0)) ^ zero-extended exact_po.
  - Seed 32'hFFFF_FFFF, applied on reset and on each accepted start.
  - Final value is valid with done.
- When undefined: no `signature` port and no MISR logic; all other behaviour is identical.

Test Plan:
- NI=7, NO=4, LAT=0; bench exact model po=pi[3:0], approx=exact -> err_count=0, max_err=0, sum_err=0; done rises 128 cycles after start; `pi` visits 0..127 once each.
- Same setup, approx_po = exact_po ^ 4'b0001 -> err_count=128, max_err=1, sum_err=128.
- Same setup, approx_po tied to 0 -> err_count=120, max_err=15, sum_err=960.
- LAT=2, both partitions registered twice, approx tied to 0 -> same metrics as the previous case; done rises 130 cycles after start.
- LAT=2, hold toggled every other SWEEP cycle (64 hold cycles) -> metrics unchanged; done delayed by exactly 64 cycles; start pulses while busy are ignored.
- rst asserted when pi=50 -> next cycle: all outputs 0, IDLE. A new start then gives full, correct metrics. With TT_SIGNATURE_EN defined, `signature` equals the bench recurrence model.

Source files
------------

// File: rtl/partition_sweep_checker.sv
// Exhaustive input sweep with exact-vs-approximate output scoring (mismatches, max/sum |error|).
// Define TT_SIGNATURE_EN to add a 32-bit MISR signature over the scored exact outputs.
module partition_sweep_checker #(
  parameter int unsigned NI  = 7,
  parameter int unsigned NO  = 4,
  parameter int unsigned LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             hold,
  input  logic [NO-1:0]    exact_po,
  input  logic [NO-1:0]    approx_po,
  output logic [NI-1:0]    pi,
  output logic             busy,
  output logic             done,
  output logic [NI:0]      err_count,
  output logic [NO-1:0]    max_err,
  output logic [NO+NI-1:0] sum_err
`ifdef TT_SIGNATURE_EN
  ,
  output logic [31:0]      signature
`endif
);

  localparam int unsigned EW = NI + 1;
  localparam int unsigned SW = NO + NI;
  localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'((LAT > 0) ? (LAT - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [NI-1:0]   pi_q, pi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [EW-1:0]   err_q, err_d;
  logic [NO-1:0]   max_q, max_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            issue_c;
  logic            score_c;
  logic            last_c;
  logic [NO-1:0]   diff_c;

  assign last_c  = (pi_q == {NI{1'b1}});
  assign issue_c = (state_q == S_SWEEP) && !hold;

  // Unsigned magnitude of the output difference
  always_comb begin
    if (exact_po >= approx_po) diff_c = exact_po - approx_po;
    else                       diff_c = approx_po - exact_po;
  end

  // Valid tag travels alongside the vector through the partitions' latency
  generate
    if (LAT == 0) begin : g_nolat
      assign score_c = issue_c;
    end else begin : g_lat
      logic [LAT-1:0] vld_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= issue_c;
          for (int i = 1; i < int'(LAT); i++) vld_q[i] <= vld_q[i-1];
        end
      end
      assign score_c = vld_q[LAT-1];
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_SWEEP;
      S_SWEEP: if (!hold && last_c) state_d = (LAT == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: if (cnt_q == DRAIN_LAST) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    pi_d  = pi_q;
    cnt_d = cnt_q;
    err_d = err_q;
    max_d = max_q;
    sum_d = sum_q;
    if (score_c) begin
      if (diff_c != '0) err_d = err_q + EW'(1);
      sum_d = sum_q + SW'(diff_c);
      if (diff_c > max_q) max_d = diff_c;
    end
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pi_d  = '0;
          err_d = '0;
          max_d = '0;
          sum_d = '0;
        end
      end
      S_SWEEP: begin
        cnt_d = '0;
        if (!hold) pi_d = pi_q + NI'(1);
      end
      S_DRAIN: cnt_d = cnt_q + CW'(1);
      default: ;
    endcase
    busy_d = (state_d == S_SWEEP) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pi_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= '0;
      max_q  <= '0;
      sum_q  <= '0;
      cnt_q  <= '0;
    end else begin
      pi_q   <= pi_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
      max_q  <= max_d;
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pi        = pi_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_count = err_q;
  assign max_err   = max_q;
  assign sum_err   = sum_q;

`ifdef TT_SIGNATURE_EN
  localparam logic [31:0] SIG_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] SIG_POLY = 32'h0040_0007;

  logic [31:0] sig_q, sig_d;

  // MISR over the exact output of every scored vector; reseeded on each accepted start
  always_comb begin
    sig_d = sig_q;
    if (score_c) sig_d = ({sig_q[30:0], 1'b0} ^ (sig_q[31] ? SIG_POLY : 32'h0)) ^ 32'(exact_po);
    if ((state_q == S_IDLE || state_q == S_DONE) && start) sig_d = SIG_SEED;
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= SIG_SEED;
    else     sig_q <= sig_d;
  end

  assign signature = sig_q;
`endif

endmodule

// File: tb/tb_partition_sweep_checker.sv
// Bench for partition_sweep_checker: a LAT=0 and a LAT=2 instance share start/hold and are
// scored against a whole-sweep reference computed directly from the metric definitions.
module tb_partition_sweep_checker;

  localparam int unsigned NI = 7;
  localparam int unsigned NO = 4;
  localparam int unsigned NV = 1 << NI;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, hold;
  logic [NI-1:0]    pi0, pi2, p2a, p2b;
  logic [NO-1:0]    ex0, ap0, ex2, ap2;
  logic             busy0, busy2, done0, done2;
  logic [NI:0]      ec0, ec2;
  logic [NO-1:0]    mx0, mx2;
  logic [NO+NI-1:0] sm0, sm2;
`ifdef TT_SIGNATURE_EN
  logic [31:0]      sig0, sig2;
`endif

  int mode;
  logic [NO-1:0] lut [NV];
  int checks = 0;
  int errors = 0;

  typedef struct {
    int mode;
    int hm;
    int e_cnt;
    int e_max;
    int e_sum;
    bit from_model;
  } vec_t;

  vec_t tbl [6];

  // Partition models: exact is pi[3:0]; approx chosen by mode
  assign ex0 = pi0[NO-1:0];
  assign ap0 = (mode == 0) ? pi0[NO-1:0] :
               (mode == 1) ? (pi0[NO-1:0] ^ 4'b0001) :
               (mode == 2) ? 4'b0000 : lut[pi0];

  always @(posedge clk) begin
    p2a <= pi2;
    p2b <= p2a;
  end
  assign ex2 = p2b[NO-1:0];
  assign ap2 = (mode == 0) ? p2b[NO-1:0] :
               (mode == 1) ? (p2b[NO-1:0] ^ 4'b0001) :
               (mode == 2) ? 4'b0000 : lut[p2b];

  partition_sweep_checker #(.NI(NI), .NO(NO), .LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .exact_po(ex0), .approx_po(ap0), .pi(pi0), .busy(busy0), .done(done0),
    .err_count(ec0), .max_err(mx0), .sum_err(sm0)
`ifdef TT_SIGNATURE_EN
    , .signature(sig0)
`endif
  );

  partition_sweep_checker #(.NI(NI), .NO(NO), .LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .exact_po(ex2), .approx_po(ap2), .pi(pi2), .busy(busy2), .done(done2),
    .err_count(ec2), .max_err(mx2), .sum_err(sm2)
`ifdef TT_SIGNATURE_EN
    , .signature(sig2)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: score every vector 0..NV-1 once, in ascending order
  task automatic model(input int m, output int cnt, output int mx, output int sm,
                       output logic [31:0] sig);
    int e, a, d;
    cnt = 0; mx = 0; sm = 0; sig = 32'hFFFF_FFFF;
    for (int v = 0; v < int'(NV); v++) begin
      e = v % 16;
      case (m)
        0: a = e;
        1: a = e ^ 1;
        2: a = 0;
        default: a = int'(lut[v]);
      endcase
      d = (e > a) ? (e - a) : (a - e);
      if (d != 0) cnt++;
      sm += d;
      if (d > mx) mx = d;
      sig = {sig[30:0], 1'b0} ^ (sig[31] ? 32'h0040_0007 : 32'h0) ^ 32'(e);
    end
  endtask

  task automatic run_sweep(input int r, input vec_t t);
    int issued = 0, holds = 0, edges = 0, d0_at = -1, d2_at = -1;
    int pib0 = 0, pib2 = 0, bb0 = 0, bb2 = 0;
    int m_cnt, m_max, m_sum;
    logic [31:0] m_sig;
    logic [NI:0] c0_ec, c2_ec;
    logic [NO-1:0] c0_mx, c2_mx;
    logic [NO+NI-1:0] c0_sm, c2_sm;
    logic [NI-1:0] exp_pi;
    logic h;
    c0_ec = '0; c2_ec = '0; c0_mx = '0; c2_mx = '0; c0_sm = '0; c2_sm = '0;
    mode = t.mode;
    if (t.mode == 3) for (int v = 0; v < int'(NV); v++) lut[v] = NO'($urandom);
    model(t.mode, m_cnt, m_max, m_sum, m_sig);
    if (!t.from_model) begin
      m_cnt = t.e_cnt; m_max = t.e_max; m_sum = t.e_sum;
    end
    @(negedge clk); start = 1'b1; hold = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    while ((d0_at < 0 || d2_at < 0) && edges < 1000) begin
      exp_pi = NI'(issued % int'(NV));
      if (pi0 !== exp_pi) pib0++;
      if (pi2 !== exp_pi) pib2++;
      if (d0_at < 0 && busy0 !== 1'b1) bb0++;
      if (d2_at < 0 && busy2 !== 1'b1) bb2++;
      if (issued < int'(NV)) begin
        case (t.hm)
          1:       h = (edges % 2 == 1) && (edges < int'(NV));
          2:       h = ($urandom_range(3) == 0);
          default: h = 1'b0;
        endcase
        start = (t.hm == 1) && (edges % 9 == 4);
        if (h) holds++; else issued++;
      end else begin
        h = 1'($urandom_range(1));
        start = 1'b0;
      end
      hold = h;
      @(posedge clk); edges++; #1;
      if (d0_at < 0 && done0 === 1'b1) begin
        d0_at = edges; c0_ec = ec0; c0_mx = mx0; c0_sm = sm0;
        if (busy0 !== 1'b0) bb0++;
      end
      if (d2_at < 0 && done2 === 1'b1) begin
        d2_at = edges; c2_ec = ec2; c2_mx = mx2; c2_sm = sm2;
        if (busy2 !== 1'b0) bb2++;
      end
    end
    hold = 1'b0; start = 1'b0;
    check($sformatf("run%0d done latency lat0", r), 64'(d0_at), 64'(int'(NV) + holds));
    check($sformatf("run%0d done latency lat2", r), 64'(d2_at), 64'(int'(NV) + 2 + holds));
    check($sformatf("run%0d pi sequence lat0 bad cycles", r), 64'(pib0), 64'(0));
    check($sformatf("run%0d pi sequence lat2 bad cycles", r), 64'(pib2), 64'(0));
    check($sformatf("run%0d busy window lat0 bad cycles", r), 64'(bb0), 64'(0));
    check($sformatf("run%0d busy window lat2 bad cycles", r), 64'(bb2), 64'(0));
    check($sformatf("run%0d err_count at done lat0", r), 64'(c0_ec), 64'(m_cnt));
    check($sformatf("run%0d max_err at done lat0", r), 64'(c0_mx), 64'(m_max));
    check($sformatf("run%0d sum_err at done lat0", r), 64'(c0_sm), 64'(m_sum));
    check($sformatf("run%0d err_count at done lat2", r), 64'(c2_ec), 64'(m_cnt));
    check($sformatf("run%0d max_err at done lat2", r), 64'(c2_mx), 64'(m_max));
    check($sformatf("run%0d sum_err at done lat2", r), 64'(c2_sm), 64'(m_sum));
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("run%0d done held lat0", r), 64'(done0), 64'(1));
    check($sformatf("run%0d done held lat2", r), 64'(done2), 64'(1));
    check($sformatf("run%0d err_count stable lat0", r), 64'(ec0), 64'(m_cnt));
    check($sformatf("run%0d sum_err stable lat2", r), 64'(sm2), 64'(m_sum));
`ifdef TT_SIGNATURE_EN
    check($sformatf("run%0d signature lat0", r), 64'(sig0), 64'(m_sig));
    check($sformatf("run%0d signature lat2", r), 64'(sig2), 64'(m_sig));
`endif
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " pi lat0"}, 64'(pi0), 64'(0));
    check({tag, " pi lat2"}, 64'(pi2), 64'(0));
    check({tag, " busy lat0"}, 64'(busy0), 64'(0));
    check({tag, " busy lat2"}, 64'(busy2), 64'(0));
    check({tag, " done lat0"}, 64'(done0), 64'(0));
    check({tag, " done lat2"}, 64'(done2), 64'(0));
    check({tag, " err_count lat0"}, 64'(ec0), 64'(0));
    check({tag, " err_count lat2"}, 64'(ec2), 64'(0));
    check({tag, " max_err lat0"}, 64'(mx0), 64'(0));
    check({tag, " max_err lat2"}, 64'(mx2), 64'(0));
    check({tag, " sum_err lat0"}, 64'(sm0), 64'(0));
    check({tag, " sum_err lat2"}, 64'(sm2), 64'(0));
`ifdef TT_SIGNATURE_EN
    check({tag, " signature seed lat0"}, 64'(sig0), 64'(32'hFFFF_FFFF));
    check({tag, " signature seed lat2"}, 64'(sig2), 64'(32'hFFFF_FFFF));
`endif
  endtask

  initial begin
    int found;
    vec_t extra;
    tbl[0] = '{mode: 0, hm: 0, e_cnt: 0,   e_max: 0,  e_sum: 0,   from_model: 1'b0};
    tbl[1] = '{mode: 1, hm: 0, e_cnt: 128, e_max: 1,  e_sum: 128, from_model: 1'b0};
    tbl[2] = '{mode: 2, hm: 0, e_cnt: 120, e_max: 15, e_sum: 960, from_model: 1'b0};
    tbl[3] = '{mode: 2, hm: 1, e_cnt: 120, e_max: 15, e_sum: 960, from_model: 1'b0};
    tbl[4] = '{mode: 3, hm: 2, e_cnt: 0,   e_max: 0,  e_sum: 0,   from_model: 1'b1};
    tbl[5] = '{mode: 1, hm: 1, e_cnt: 128, e_max: 1,  e_sum: 128, from_model: 1'b0};
    for (int v = 0; v < int'(NV); v++) lut[v] = '0;
    mode = 0; rst = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_sweep(i, tbl[i]);

    // Reset in the middle of a sweep
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    found = 0;
    for (int c = 0; c < 300 && found == 0; c++) begin
      if (pi0 == NI'(50)) found = 1;
      else begin @(posedge clk); #1; end
    end
    check("midsweep reached pi 50", 64'(found), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check_cleared("midsweep reset");
    repeat (2) @(posedge clk);
    #1;
    check("midsweep idle busy lat0", 64'(busy0), 64'(0));
    check("midsweep idle done lat2", 64'(done2), 64'(0));
    extra = '{mode: 3, hm: 2, e_cnt: 0, e_max: 0, e_sum: 0, from_model: 1'b1};
    run_sweep(6, extra);

    // Reset and start on the same edge: reset wins
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1; rst = 1'b0; start = 1'b0;
    check("rst+start busy lat0", 64'(busy0), 64'(0));
    check("rst+start busy lat2", 64'(busy2), 64'(0));
    @(posedge clk); #1;
    check("rst+start still idle lat0", 64'(busy0), 64'(0));
    check("rst+start pi lat2", 64'(pi2), 64'(0));
    extra = '{mode: 2, hm: 0, e_cnt: 120, e_max: 15, e_sum: 960, from_model: 1'b0};
    run_sweep(7, extra);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
